// File: rtl/alu16_sequencer_if.sv
// Bundle of request, ALU-drive and completion signals for the 16-bit op sequencer.
// master: control unit / ALU side. slave: the sequencer itself.
interface alu16_sequencer_if;
    logic        START;
    logic [1:0]  OP;
    logic [15:0] A16;
    logic [15:0] B16;
    logic [3:0]  FLAGS_IN;
    logic [4:0]  ALU_FUN;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FLAGS_IN;
    logic [7:0]  ALU_OUT;
    logic [3:0]  ALU_FLAGS_OUT;
    logic [15:0] RESULT;
    logic [3:0]  FLAGS_OUT;
    logic        BUSY;
    logic        DONE;

    modport master (
        output START, OP, A16, B16, FLAGS_IN, ALU_OUT, ALU_FLAGS_OUT,
        input  ALU_FUN, ALU_A, ALU_B, ALU_FLAGS_IN, RESULT, FLAGS_OUT, BUSY, DONE
    );

    modport slave (
        input  START, OP, A16, B16, FLAGS_IN, ALU_OUT, ALU_FLAGS_OUT,
        output ALU_FUN, ALU_A, ALU_B, ALU_FLAGS_IN, RESULT, FLAGS_OUT, BUSY, DONE
    );
endinterface

// File: rtl/alu16_sequencer.sv
// Drives the 8-bit ALU through a low-byte then high-byte pass to perform
// ADD HL,rr / INC rr / DEC rr / ADD SP,e8, chaining carry between passes.
//
// state | meaning
// IDLE  | waiting for START; ALU driven with ADD 0,0
// LO    | low-byte pass, ALU result/flags captured at the edge
// HI    | high-byte pass with carry-in from LO; RESULT/FLAGS_OUT written at the edge
// FIN   | DONE pulse, then back to IDLE
module alu16_sequencer (
    input  logic               CLK,
    input  logic               RST,
    alu16_sequencer_if.slave   bus
);
    localparam logic [4:0] FUN_ADD = 5'b00000;
    localparam logic [4:0] FUN_ADC = 5'b00001;
    localparam logic [4:0] FUN_SUB = 5'b00010;
    localparam logic [4:0] FUN_SBC = 5'b00011;

    localparam logic [1:0] OP_ADD16 = 2'b00;
    localparam logic [1:0] OP_INC16 = 2'b01;
    localparam logic [1:0] OP_DEC16 = 2'b10;
    localparam logic [1:0] OP_ADDSP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  flags_q;
    logic [7:0]  res_lo;
    logic [3:0]  lo_flags;
    logic [15:0] result_q;
    logic [3:0]  flags_out_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; START only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = LO;
            LO:      state_nxt = HI;
            HI:      state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch on acceptance, so later input changes cannot disturb a running op
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q    <= 2'b00;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            flags_q <= 4'b0000;
        end else if (state == IDLE && bus.START) begin
            op_q    <= bus.OP;
            a_q     <= bus.A16;
            b_q     <= bus.B16;
            flags_q <= bus.FLAGS_IN;
        end
    end

    // Low-byte capture and final result/flag assembly
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_lo      <= 8'h00;
            lo_flags    <= 4'b0000;
            result_q    <= 16'h0000;
            flags_out_q <= 4'b0000;
        end else begin
            if (state == LO) begin
                res_lo   <= bus.ALU_OUT;
                lo_flags <= bus.ALU_FLAGS_OUT;
            end
            if (state == HI) begin
                result_q <= {bus.ALU_OUT, res_lo};
                case (op_q)
                    OP_ADD16: flags_out_q <= {flags_q[3], 1'b0, bus.ALU_FLAGS_OUT[1:0]};
                    OP_ADDSP: flags_out_q <= {2'b00, lo_flags[1:0]};
                    default:  flags_out_q <= flags_q;
                endcase
            end
        end
    end

    // ALU drive: purely from state and latched operands, never from live inputs
    always_comb begin
        bus.ALU_FUN      = FUN_ADD;
        bus.ALU_A        = 8'h00;
        bus.ALU_B        = 8'h00;
        bus.ALU_FLAGS_IN = 4'b0000;
        case (state)
            LO: begin
                bus.ALU_A = a_q[7:0];
                case (op_q)
                    OP_INC16: bus.ALU_B = 8'h01;
                    OP_DEC16: begin
                        bus.ALU_FUN = FUN_SUB;
                        bus.ALU_B   = 8'h01;
                    end
                    default:  bus.ALU_B = b_q[7:0];
                endcase
            end
            HI: begin
                bus.ALU_A        = a_q[15:8];
                bus.ALU_FLAGS_IN = {3'b000, lo_flags[0]};
                bus.ALU_FUN      = FUN_ADC;
                case (op_q)
                    OP_ADD16: bus.ALU_B = b_q[15:8];
                    OP_INC16: bus.ALU_B = 8'h00;
                    OP_DEC16: begin
                        bus.ALU_FUN = FUN_SBC;
                        bus.ALU_B   = 8'h00;
                    end
                    OP_ADDSP: bus.ALU_B = {8{b_q[7]}};
                    default:  bus.ALU_B = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

    // Status and held outputs
    always_comb begin
        bus.BUSY      = (state != IDLE);
        bus.DONE      = (state == FIN);
        bus.RESULT    = result_q;
        bus.FLAGS_OUT = flags_out_q;
    end
endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a behavioural 8-bit ALU attached.
module tb_alu16_sequencer;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;
    int   done_cnt;

    alu16_sequencer_if bus ();

    alu16_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Reference 8-bit ALU: ADD/ADC/SUB/SBC with [Z,N,H,C] flags
    always_comb begin
        logic       cin;
        logic [8:0] s;
        logic [4:0] h;
        cin = (bus.ALU_FUN == 5'b00001 || bus.ALU_FUN == 5'b00011) ? bus.ALU_FLAGS_IN[0] : 1'b0;
        if (bus.ALU_FUN == 5'b00010 || bus.ALU_FUN == 5'b00011) begin
            s = {1'b0, bus.ALU_A} - {1'b0, bus.ALU_B} - {8'h00, cin};
            h = {1'b0, bus.ALU_A[3:0]} - {1'b0, bus.ALU_B[3:0]} - {4'h0, cin};
            bus.ALU_OUT       = s[7:0];
            bus.ALU_FLAGS_OUT = {(s[7:0] == 8'h00), 1'b1, h[4], s[8]};
        end else begin
            s = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B} + {8'h00, cin};
            h = {1'b0, bus.ALU_A[3:0]} + {1'b0, bus.ALU_B[3:0]} + {4'h0, cin};
            bus.ALU_OUT       = s[7:0];
            bus.ALU_FLAGS_OUT = {(s[7:0] == 8'h00), 1'b0, h[4], s[8]};
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and check the full timing: accept at edge N, DONE after N+2, idle after N+3
    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] f,
                          input logic [15:0] exp_res, input logic [3:0] exp_f);
        bus.START = 1'b1; bus.OP = op; bus.A16 = a; bus.B16 = b; bus.FLAGS_IN = f;
        @(posedge CLK); @(negedge CLK);
        bus.START = 1'b0;
        check({tag, " busy_lo"}, {15'd0, bus.BUSY}, 16'd1);
        check({tag, " done_lo"}, {15'd0, bus.DONE}, 16'd0);
        @(posedge CLK); @(negedge CLK);
        check({tag, " done_hi"}, {15'd0, bus.DONE}, 16'd0);
        @(posedge CLK); @(negedge CLK);
        check({tag, " done_fin"}, {15'd0, bus.DONE}, 16'd1);
        check({tag, " result"}, bus.RESULT, exp_res);
        check({tag, " flags"}, {12'd0, bus.FLAGS_OUT}, {12'd0, exp_f});
        @(posedge CLK); @(negedge CLK);
        check({tag, " done_after"}, {15'd0, bus.DONE}, 16'd0);
        check({tag, " busy_after"}, {15'd0, bus.BUSY}, 16'd0);
        check({tag, " result_hold"}, bus.RESULT, exp_res);
    endtask

    initial begin
        bus.START = 1'b0; bus.OP = 2'b00; bus.A16 = 16'h0000; bus.B16 = 16'h0000;
        bus.FLAGS_IN = 4'b0000;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("reset busy", {15'd0, bus.BUSY}, 16'd0);
        check("reset done", {15'd0, bus.DONE}, 16'd0);
        check("reset result", bus.RESULT, 16'h0000);
        check("reset flags", {12'd0, bus.FLAGS_OUT}, 16'h0000);
        check("idle alu_a", {8'd0, bus.ALU_A}, 16'h0000);

        run_op("add16",    2'b00, 16'h8A23, 16'h0605, 4'b1000, 16'h9028, 4'b1010);
        run_op("add16wrap", 2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
        run_op("inc16",    2'b01, 16'h00FF, 16'h1234, 4'b0101, 16'h0100, 4'b0101);
        run_op("dec16",    2'b10, 16'h0000, 16'hABCD, 4'b1010, 16'hFFFF, 4'b1010);
        run_op("addsp_neg", 2'b11, 16'h000F, 16'h00FF, 4'b1111, 16'h000E, 4'b0011);
        run_op("addsp_pos", 2'b11, 16'hFFF8, 16'h0002, 4'b1111, 16'hFFFA, 4'b0000);

        // START while busy: A16 changed in LO, second START pulsed in HI
        done_cnt = 0;
        bus.START = 1'b1; bus.OP = 2'b00; bus.A16 = 16'h8A23; bus.B16 = 16'h0605;
        bus.FLAGS_IN = 4'b1000;
        @(posedge CLK); @(negedge CLK);
        bus.START = 1'b0; bus.A16 = 16'h1111;
        @(posedge CLK); @(negedge CLK);
        bus.START = 1'b1; bus.B16 = 16'h2222; bus.FLAGS_IN = 4'b0000;
        @(posedge CLK); @(negedge CLK);
        bus.START = 1'b0;
        if (bus.DONE) done_cnt++;
        check("busy result", bus.RESULT, 16'h9028);
        check("busy flags", {12'd0, bus.FLAGS_OUT}, 16'h000A);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); @(negedge CLK);
            if (bus.DONE) done_cnt++;
        end
        check("busy done count", done_cnt[15:0], 16'd1);
        check("busy result hold", bus.RESULT, 16'h9028);

        // Reset during HI
        done_cnt = 0;
        bus.START = 1'b1; bus.OP = 2'b00; bus.A16 = 16'h1234; bus.B16 = 16'h1111;
        bus.FLAGS_IN = 4'b1000;
        @(posedge CLK); @(negedge CLK);
        bus.START = 1'b0;
        @(posedge CLK); @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        check("rst busy", {15'd0, bus.BUSY}, 16'd0);
        check("rst result", bus.RESULT, 16'h0000);
        check("rst flags", {12'd0, bus.FLAGS_OUT}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            if (bus.DONE) done_cnt++;
            @(posedge CLK); @(negedge CLK);
        end
        check("rst no done", done_cnt[15:0], 16'd0);
        run_op("post_rst", 2'b00, 16'h1234, 16'h1111, 4'b0000, 16'h2345, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
